// File: rtl/vector_regfile_sb_if.sv
// Bus bundle for vector_regfile_sb: write port, dual read port with handshake,
// reservation (scoreboard) port and zero-clear control.
interface vector_regfile_sb_if #(
  parameter int LANES = 4,
  parameter int AW    = 3
);
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [32*LANES-1:0]   wdata;
  logic [LANES-1:0]      wmask;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [AW-1:0]         raddr_a;
  logic [AW-1:0]         raddr_b;
  logic [32*LANES-1:0]   rdata_a;
  logic [32*LANES-1:0]   rdata_b;
  logic                  rdata_valid;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic                  busy_a;
  logic                  busy_b;
  logic                  clr_start;
  logic                  clr_busy;

  modport master (
    output we, waddr, wdata, wmask, rd_valid, raddr_a, raddr_b,
           rsv_en, rsv_addr, clr_start,
    input  rd_ready, rdata_a, rdata_b, rdata_valid, busy_a, busy_b, clr_busy
  );

  modport slave (
    input  we, waddr, wdata, wmask, rd_valid, raddr_a, raddr_b,
           rsv_en, rsv_addr, clr_start,
    output rd_ready, rdata_a, rdata_b, rdata_valid, busy_a, busy_b, clr_busy
  );
endinterface

// File: rtl/vector_regfile_sb.sv
// Vector register file with per-lane masked writes, 2 registered read ports with
// write bypass, a pending-bit scoreboard and a sequential zero-clear engine.

// Per-lane read bypass: a same-cycle write to the read register wins for enabled lanes.
module vector_regfile_sb_lane (
  input  logic [31:0] i_st_a,
  input  logic [31:0] i_st_b,
  input  logic [31:0] i_wdata,
  input  logic        i_hit_a,
  input  logic        i_hit_b,
  output logic [31:0] o_a,
  output logic [31:0] o_b
);
  assign o_a = i_hit_a ? i_wdata : i_st_a;
  assign o_b = i_hit_b ? i_wdata : i_st_b;
endmodule

module vector_regfile_sb #(
  parameter int LANES = 4,
  parameter int REGS  = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  vector_regfile_sb_if.slave  bus
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(REGS-1);

  state_t                              r_state, w_state_nx;
  logic [AW-1:0]                       r_clr_idx, w_clr_idx_nx;
  logic [REGS-1:0][LANES-1:0][31:0]    r_mem;
  logic [REGS-1:0]                     r_pend;
  logic [LANES-1:0][31:0]              r_rdata_a, r_rdata_b;
  logic                                r_rvalid;

  logic [LANES-1:0][31:0]              w_wdata, w_st_a, w_st_b, w_byp_a, w_byp_b;
  logic                                w_clr_busy, w_rd_acc, w_wr_ok, w_rsv_ok;
  logic                                w_hit_a, w_hit_b, w_busy_a, w_busy_b;

  assign w_wdata    = bus.wdata;
  assign w_clr_busy = (r_state == S_CLEAR);
  assign w_rd_acc   = bus.rd_valid && !w_clr_busy;
  // Out-of-range writes/reservations are dropped here so they never alias or bypass.
  assign w_wr_ok    = bus.we     && !w_clr_busy && (int'(bus.waddr)    < REGS);
  assign w_rsv_ok   = bus.rsv_en && !w_clr_busy && (int'(bus.rsv_addr) < REGS);
  assign w_hit_a    = w_wr_ok && (bus.waddr == bus.raddr_a);
  assign w_hit_b    = w_wr_ok && (bus.waddr == bus.raddr_b);

  // Stored-data and pending lookup; unmatched (out-of-range) indices fall to 0.
  always_comb begin
    w_st_a   = '0;
    w_st_b   = '0;
    w_busy_a = 1'b0;
    w_busy_b = 1'b0;
    for (int r = 0; r < REGS; r++) begin
      if (bus.raddr_a == AW'(r)) begin
        w_st_a   = r_mem[r];
        w_busy_a = r_pend[r];
      end
      if (bus.raddr_b == AW'(r)) begin
        w_st_b   = r_mem[r];
        w_busy_b = r_pend[r];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vector_regfile_sb_lane u_lane (
      .i_st_a  (w_st_a[l]),
      .i_st_b  (w_st_b[l]),
      .i_wdata (w_wdata[l]),
      .i_hit_a (w_hit_a && bus.wmask[l]),
      .i_hit_b (w_hit_b && bus.wmask[l]),
      .o_a     (w_byp_a[l]),
      .o_b     (w_byp_b[l])
    );
  end

  always_comb begin
    w_state_nx   = r_state;
    w_clr_idx_nx = r_clr_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_start) begin
          w_state_nx   = S_CLEAR;
          w_clr_idx_nx = '0;
        end
      end
      S_CLEAR: begin
        if (r_clr_idx == LAST_IDX) begin
          w_state_nx   = S_IDLE;
          w_clr_idx_nx = '0;
        end else begin
          w_clr_idx_nx = r_clr_idx + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_idx <= w_clr_idx_nx;
    end
  end

  // Storage and scoreboard; a reservation is applied after the write-clear so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_pend <= '0;
    end else begin
      for (int r = 0; r < REGS; r++) begin
        if (w_clr_busy) begin
          if (r_clr_idx == AW'(r)) begin
            r_mem[r]  <= '0;
            r_pend[r] <= 1'b0;
          end
        end else begin
          if (w_wr_ok && (bus.waddr == AW'(r))) begin
            for (int l = 0; l < LANES; l++)
              if (bus.wmask[l]) r_mem[r][l] <= w_wdata[l];
            r_pend[r] <= 1'b0;
          end
          if (w_rsv_ok && (bus.rsv_addr == AW'(r))) r_pend[r] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata_a <= w_byp_a;
        r_rdata_b <= w_byp_b;
      end
    end
  end

  assign bus.rd_ready    = !w_clr_busy;
  assign bus.rdata_a     = r_rdata_a;
  assign bus.rdata_b     = r_rdata_b;
  assign bus.rdata_valid = r_rvalid;
  assign bus.busy_a      = w_busy_a;
  assign bus.busy_b      = w_busy_b;
  assign bus.clr_busy    = w_clr_busy;
endmodule

// File: tb/tb_vector_regfile_sb.sv
// Directed bench for vector_regfile_sb (LANES=4, REGS=8, AW=4 so address 9 is reachable).
module tb_vector_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vector_regfile_sb_if #(.LANES(4), .AW(4)) bus ();

  vector_regfile_sb #(.LANES(4), .REGS(8), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wmask = '0;
    bus.rd_valid = 1'b0; bus.raddr_a = '0; bus.raddr_b = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.clr_start = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (bus.rdata_a !== 128'h0) begin failures++; $display("FAIL rst_rdata_a: got %h want 0", bus.rdata_a); end
    checks++; if (bus.rdata_b !== 128'h0) begin failures++; $display("FAIL rst_rdata_b: got %h want 0", bus.rdata_b); end
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL rst_rdata_valid: got %b want 0", bus.rdata_valid); end
    checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL rst_clr_busy: got %b want 0", bus.clr_busy); end
    checks++; if (bus.rd_ready !== 1'b1) begin failures++; $display("FAIL rst_rd_ready: got %b want 1", bus.rd_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid: got %b want 0", bus.rdata_valid); end
  endtask

  task automatic test_write_read;
    logic [127:0] exp;
    exp = 128'h00000044_00000033_00000022_00000011;
    bus.we = 1'b1; bus.waddr = 4'd3; bus.wdata = exp; bus.wmask = 4'hF;
    tick();
    bus.we = 1'b0; bus.rd_valid = 1'b1; bus.raddr_a = 4'd3; bus.raddr_b = 4'd0;
    tick();
    bus.rd_valid = 1'b0;
    checks++; if (bus.rdata_a !== exp) begin failures++; $display("FAIL wr_rd_a: got %h want %h", bus.rdata_a, exp); end
    checks++; if (bus.rdata_b !== 128'h0) begin failures++; $display("FAIL wr_rd_b: got %h want 0", bus.rdata_b); end
    checks++; if (bus.rdata_valid !== 1'b1) begin failures++; $display("FAIL wr_rd_valid: got %b want 1", bus.rdata_valid); end
    tick();
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_valid_pulse: got %b want 0", bus.rdata_valid); end
    checks++; if (bus.rdata_a !== exp) begin failures++; $display("FAIL wr_rd_hold: got %h want %h", bus.rdata_a, exp); end
  endtask

  task automatic test_bypass;
    logic [127:0] exp;
    exp = 128'h00000044_000000AA_00000022_000000AA;
    bus.we = 1'b1; bus.waddr = 4'd3; bus.wdata = {4{32'h000000AA}}; bus.wmask = 4'b0101;
    bus.rd_valid = 1'b1; bus.raddr_a = 4'd3;
    tick();
    bus.we = 1'b0; bus.rd_valid = 1'b0;
    checks++; if (bus.rdata_a !== exp) begin failures++; $display("FAIL bypass_a: got %h want %h", bus.rdata_a, exp); end
    bus.rd_valid = 1'b1;
    tick();
    bus.rd_valid = 1'b0;
    checks++; if (bus.rdata_a !== exp) begin failures++; $display("FAIL bypass_stored: got %h want %h", bus.rdata_a, exp); end
  endtask

  task automatic test_pending;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd5;
    tick();
    bus.rsv_en = 1'b0; bus.raddr_a = 4'd5; bus.raddr_b = 4'd4;
    #1;
    checks++; if (bus.busy_a !== 1'b1) begin failures++; $display("FAIL pend_set: got %b want 1", bus.busy_a); end
    checks++; if (bus.busy_b !== 1'b0) begin failures++; $display("FAIL pend_other: got %b want 0", bus.busy_b); end
    bus.we = 1'b1; bus.waddr = 4'd5; bus.wmask = 4'h0; bus.wdata = '0;
    tick();
    bus.we = 1'b0;
    #1;
    checks++; if (bus.busy_a !== 1'b0) begin failures++; $display("FAIL pend_wr_clear: got %b want 0", bus.busy_a); end
    bus.we = 1'b1; bus.waddr = 4'd5; bus.rsv_en = 1'b1; bus.rsv_addr = 4'd5;
    tick();
    bus.we = 1'b0; bus.rsv_en = 1'b0;
    #1;
    checks++; if (bus.busy_a !== 1'b1) begin failures++; $display("FAIL pend_set_prio: got %b want 1", bus.busy_a); end
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd2;
    tick();
    bus.rsv_en = 1'b0;
  endtask

  task automatic test_clear;
    int n, bad_rdy, bad_vld;
    bus.we = 1'b1; bus.waddr = 4'd7; bus.wdata = {4{32'h77777777}}; bus.wmask = 4'hF;
    tick();
    idle_inputs();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    bus.we = 1'b1; bus.waddr = 4'd0; bus.wdata = {4{32'hDEADBEEF}}; bus.wmask = 4'hF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd0;
    bus.rd_valid = 1'b1; bus.raddr_a = 4'd3;
    n = 0; bad_rdy = 0; bad_vld = 0;
    while (bus.clr_busy === 1'b1 && n < 20) begin
      n++;
      if (bus.rd_ready !== 1'b0) bad_rdy++;
      if (bus.rdata_valid !== 1'b0) bad_vld++;
      tick();
    end
    idle_inputs();
    checks++; if (n != 8) begin failures++; $display("FAIL clr_cycles: got %0d want 8", n); end
    checks++; if (bad_rdy != 0) begin failures++; $display("FAIL clr_rd_ready: got %0d high cycles want 0", bad_rdy); end
    checks++; if (bad_vld != 0) begin failures++; $display("FAIL clr_rdata_valid: got %0d pulses want 0", bad_vld); end
    for (int k = 0; k < 4; k++) begin
      bus.rd_valid = 1'b1; bus.raddr_a = 4'(2*k); bus.raddr_b = 4'(2*k+1);
      tick();
      bus.rd_valid = 1'b0;
      checks++; if (bus.rdata_a !== 128'h0) begin failures++; $display("FAIL clr_read_r%0d: got %h want 0", 2*k, bus.rdata_a); end
      checks++; if (bus.rdata_b !== 128'h0) begin failures++; $display("FAIL clr_read_r%0d: got %h want 0", 2*k+1, bus.rdata_b); end
    end
    for (int r = 0; r < 8; r++) begin
      bus.raddr_a = 4'(r);
      #1;
      checks++; if (bus.busy_a !== 1'b0) begin failures++; $display("FAIL clr_busy_r%0d: got %b want 0", r, bus.busy_a); end
    end
  endtask

  task automatic test_reset_mid_clear;
    idle_inputs();
    bus.we = 1'b1; bus.waddr = 4'd1; bus.wdata = {4{32'h11111111}}; bus.wmask = 4'hF;
    tick();
    bus.waddr = 4'd6; bus.wdata = {4{32'h66666666}}; bus.rsv_en = 1'b1; bus.rsv_addr = 4'd6;
    tick();
    idle_inputs();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (4) tick();
    checks++; if (bus.clr_busy !== 1'b1) begin failures++; $display("FAIL mid_clr_active: got %b want 1", bus.clr_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL mid_clr_async: got %b want 0", bus.clr_busy); end
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL mid_clr_idle: got %b want 0", bus.clr_busy); end
    bus.rd_valid = 1'b1; bus.raddr_a = 4'd6; bus.raddr_b = 4'd1;
    tick();
    bus.rd_valid = 1'b0;
    checks++; if (bus.rdata_a !== 128'h0) begin failures++; $display("FAIL mid_clr_r6: got %h want 0", bus.rdata_a); end
    checks++; if (bus.rdata_b !== 128'h0) begin failures++; $display("FAIL mid_clr_r1: got %h want 0", bus.rdata_b); end
    checks++; if (bus.busy_a !== 1'b0) begin failures++; $display("FAIL mid_clr_pend6: got %b want 0", bus.busy_a); end
  endtask

  task automatic test_out_of_range;
    logic [127:0] r1v;
    r1v = 128'h0000C0DE_0000C0DE_0000C0DE_0000C0DE;
    idle_inputs();
    bus.we = 1'b1; bus.waddr = 4'd1; bus.wdata = r1v; bus.wmask = 4'hF;
    tick();
    bus.waddr = 4'd9; bus.wdata = {4{32'hBAD0BAD0}};
    bus.rd_valid = 1'b1; bus.raddr_a = 4'd9; bus.raddr_b = 4'd1;
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd9;
    tick();
    bus.we = 1'b0; bus.rd_valid = 1'b0; bus.rsv_en = 1'b0;
    checks++; if (bus.rdata_a !== 128'h0) begin failures++; $display("FAIL oor_read9: got %h want 0", bus.rdata_a); end
    checks++; if (bus.rdata_b !== r1v) begin failures++; $display("FAIL oor_r1_same: got %h want %h", bus.rdata_b, r1v); end
    #1;
    checks++; if (bus.busy_a !== 1'b0) begin failures++; $display("FAIL oor_busy9: got %b want 0", bus.busy_a); end
    checks++; if (bus.busy_b !== 1'b0) begin failures++; $display("FAIL oor_busy1: got %b want 0", bus.busy_b); end
    bus.rd_valid = 1'b1; bus.raddr_a = 4'd1; bus.raddr_b = 4'd9;
    tick();
    bus.rd_valid = 1'b0;
    checks++; if (bus.rdata_a !== r1v) begin failures++; $display("FAIL oor_r1_after: got %h want %h", bus.rdata_a, r1v); end
    checks++; if (bus.rdata_b !== 128'h0) begin failures++; $display("FAIL oor_read9_again: got %h want 0", bus.rdata_b); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] va, vb, vc;
    va = 128'hA0000003_A0000002_A0000001_A0000000;
    vb = 128'hB0000003_B0000002_B0000001_B0000000;
    vc = 128'hC0000003_C0000002_C0000001_C0000000;
    idle_inputs();
    bus.we = 1'b1; bus.waddr = 4'd2; bus.wdata = va; bus.wmask = 4'hF;
    tick();
    bus.waddr = 4'd4; bus.wdata = vb;
    tick();
    idle_inputs();
    bus.rd_valid = 1'b1; bus.raddr_a = 4'd2; bus.raddr_b = 4'd4;
    tick();
    checks++; if (bus.rdata_a !== va) begin failures++; $display("FAIL b2b_1a: got %h want %h", bus.rdata_a, va); end
    checks++; if (bus.rdata_b !== vb) begin failures++; $display("FAIL b2b_1b: got %h want %h", bus.rdata_b, vb); end
    bus.raddr_a = 4'd4; bus.raddr_b = 4'd2;
    bus.we = 1'b1; bus.waddr = 4'd4; bus.wdata = vc; bus.wmask = 4'hF;
    tick();
    bus.we = 1'b0; bus.rd_valid = 1'b0;
    checks++; if (bus.rdata_a !== vc) begin failures++; $display("FAIL b2b_2a: got %h want %h", bus.rdata_a, vc); end
    checks++; if (bus.rdata_b !== va) begin failures++; $display("FAIL b2b_2b: got %h want %h", bus.rdata_b, va); end
    checks++; if (bus.rdata_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b want 1", bus.rdata_valid); end
    tick();
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_end: got %b want 0", bus.rdata_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_pending();
    test_clear();
    test_reset_mid_clear();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_regfile_sb.md
VECTOR_REGFILE_SB -- requirements
Module: vector_regfile_sb

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 32-bit lanes per vector register.
REQ-002 SHALL have parameter REGS, default 8, number of vector registers (2..256).
REQ-003 SHALL have parameter AW, default 3, address width; 2^AW >= REGS.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port we  in  1  write enable.
REQ-007 SHALL have port waddr  in  AW  write register index.
REQ-008 SHALL have port wdata  in  32*LANES  write data; lane i = bits [32i+31:32i].
REQ-009 SHALL have port wmask  in  LANES  per-lane write enable.
REQ-010 SHALL have port rd_valid  in  1  read request.
REQ-011 SHALL have port rd_ready  out  1  read request accepted this cycle.
REQ-012 SHALL have ports raddr_a, raddr_b  in  AW  read register indices.
REQ-013 SHALL have ports rdata_a, rdata_b  out  32*LANES  registered read data.
REQ-014 SHALL have port rdata_valid  out  1  rdata_a/rdata_b hold a new result.
REQ-015 SHALL have ports rsv_en  in  1, rsv_addr  in  AW  mark a register pending.
REQ-016 SHALL have ports busy_a, busy_b  out  1  pending bit of raddr_a / raddr_b.
REQ-017 SHALL have port clr_start  in  1  start zero-clear sequence.
REQ-018 SHALL have port clr_busy  out  1  clear sequence in progress.

Function
REQ-019 SHALL write lane i of regs[waddr] with wdata lane i when we=1 and wmask[i]=1 and clr_busy=0; other lanes unchanged.
REQ-020 SHALL ignore writes and reservations to addresses >= REGS; reads of such addresses SHALL return 0.
REQ-021 SHALL drive rd_ready = !clr_busy combinationally; a read is accepted when rd_valid && rd_ready.
REQ-022 SHALL register rdata_a/rdata_b one cycle after acceptance (latency 1) and pulse rdata_valid high for exactly that cycle.
REQ-023 SHALL hold rdata_a/rdata_b unchanged when no read is accepted.
REQ-024 SHALL bypass same-cycle writes per lane: if a write and accepted read target the same register, enabled lanes return new wdata, masked lanes return stored data.
REQ-025 SHALL keep one pending bit per register; rsv_en sets pend[rsv_addr], any accepted write (we=1, any wmask) clears pend[waddr].
REQ-026 SHALL give set priority when rsv_en and a write target the same register in one cycle.
REQ-027 SHALL drive busy_a = pend[raddr_a], busy_b = pend[raddr_b] combinationally (0 for out-of-range).
REQ-028 SHALL implement FSM IDLE->CLEAR on clr_start=1 in IDLE; clr_start in CLEAR ignored.
REQ-029 SHALL in CLEAR zero one register per cycle, index 0 to REGS-1, clearing its pending bit; clr_busy=1 throughout.
REQ-030 SHALL return CLEAR->IDLE the cycle after index REGS-1 is cleared; clear takes exactly REGS cycles.
REQ-031 SHALL ignore we and rsv_en while clr_busy=1.

Reset
REQ-032 SHALL on rst_n=0, immediately and regardless of clk: all registers 0, all pending bits 0, FSM IDLE, clr index 0.
REQ-033 SHALL drive rdata_a=0, rdata_b=0, rdata_valid=0, clr_busy=0 during and after reset until first event.
REQ-034 SHALL abort a clear in progress on reset mid-operation; FSM resumes in IDLE.

Verification
REQ-035 Write r3=0x44..33..22..11 mask 1111, next cycle read a=3 -> one cycle later rdata_a lanes 0x11,0x22,0x33,0x44, rdata_valid=1 one cycle.
REQ-036 r3 holds lanes 0x11..0x44; write r3 lanes 0xAA mask 0101 with same-cycle read a=3 -> rdata_a lanes 0xAA,0x22,0xAA,0x44.
REQ-037 rsv_en addr 5 -> busy_a=1 for raddr_a=5; write r5 -> busy_a=0 next cycle; rsv+write r5 same cycle -> busy_a stays 1.
REQ-038 clr_start with REGS=8 -> clr_busy=1 exactly 8 cycles, rd_ready=0, writes ignored; after, all reads return 0, all busy 0.
REQ-039 Assert rst_n=0 mid-clear at index 4 -> clr_busy=0 and all registers read 0 immediately after release.
REQ-040 Write/read address 9 with REGS=8, AW=4 -> no state change, rdata_a=0.
